local_ni: RTL and testbench
===========================

// Module: local_ni
// PURPOSE
//  Local network interface for the bufferless BLESS router; sits between the core and the router's local port.
//  - Injection side: buffers core flits and drives dinLocal/PVLocal only when the router has a free input channel.
//    The router has no backpressure, so the free-channel check is made here.
//  - Ejection side: buffers flits from doutLocal, which the router delivers unconditionally, into a FIFO read by the core.
// PARAMETERS
//  INJ_DEPTH  4   injection FIFO entries (power of 2, >=2)
//  EJ_DEPTH   4   ejection FIFO entries (power of 2, >=2)
//  CNT_W      16  width of injection-stall counter
// PORTS
//  clk          in   1             clock
//  reset        in   1             async, active-high reset
//  core_flit    in   `WIDTH_PORT   flit from core; all-zero = no flit
//  core_valid   in   1             core offers core_flit
//  core_ready   out  1             injection FIFO can accept
//  dinW/E/S/N   in   `WIDTH_PORT   router mesh inputs, same cycle the router samples them (monitor only)
//  dinBypass    in   `WIDTH_PORT   router bypass input (monitor only)
//  dinLocal     out  `WIDTH_PORT   flit to router local input; 0 = idle
//  PVLocal      out  `WIDTH_PV     productive vector of dinLocal; 0 when idle
//  doutLocal    in   `WIDTH_PORT   ejected flit from router; 0 = none
//  ej_flit      out  `WIDTH_PORT   ejection FIFO head
//  ej_valid     out  1             ejection FIFO non-empty
//  ej_ready     in   1             core consumes ej_flit
//  ej_overflow  out  1             sticky: ejected flit dropped
//  inj_stall    out  CNT_W         saturating count of blocked-injection cycles
// BEHAVIOUR
//  Reset: asynchronous and active-high. All pointers and counts clear; FIFOs empty; every output is 0,
//   except core_ready = 1 once reset deasserts. Reset mid-operation discards all buffered flits.
//  Push: push_inj = core_valid & core_ready & (core_flit != 0). A zero flit is never written.
//  core_ready = ~inj_full. No combinational path from pop to core_ready, so push while full is refused even on a pop cycle.
//  free = (dinW==0)|(dinE==0)|(dinS==0)|(dinN==0)|(dinBypass==0).
//   Conservative: a same-cycle local ejection is not counted as freeing a channel.
//  Pop: pop_inj = ~inj_empty & free.
//   dinLocal = pop_inj ? inj_head : 0.  PVLocal = pop_inj ? routeComp(head) : 0.  Both combinational.
//  Injection latency: a flit pushed in cycle t is first eligible in cycle t+1. No empty-FIFO bypass.
//  Injection order is FIFO. Simultaneous push and pop is allowed at any occupancy below full.
//  inj_stall increments when ~inj_empty & ~free, and saturates at all-ones (no wrap).
//  Ejection: push_ej = (doutLocal != 0) & (~ej_full | pop_ej), where pop_ej = ej_valid & ej_ready.
//   So a full FIFO accepts a new flit in the same cycle the core pops.
//  Drop: doutLocal != 0 & ej_full & ~pop_ej drops the flit; ej_overflow sets next cycle and holds until reset.
//  ej_flit/ej_valid come from registered FIFO state. A flit on doutLocal in cycle t gives ej_valid in t+1.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy count is log2(DEPTH)+1 bits.
// STRUCTURE
//  Shared package/global.v: `WIDTH_PORT, `WIDTH_PV, `POS_X_DST, `POS_Y_DST, and the PV bit order
//   (same encoding the router's allocator consumes).
//  Sub-module ni_fifo #(WIDTH, DEPTH): sync FIFO with push/pop/full/empty/head.
//   Instantiated twice (injection, ejection).
//  Reuse existing routeComp for PVLocal: valid=~inj_empty, x/y dst taken from inj_head.
//  Top-level glue: free detect, pop/push gating, stall counter, overflow flag.
// TESTING
//  1 Reset: assert reset mid-traffic with 3 flits queued.
//    -> dinLocal=0, PVLocal=0, ej_valid=0, ej_overflow=0, inj_stall=0 immediately.
//    -> core_ready=1 after deassert.
//  2 Idle-network inject: all din*=0; push flits A, B in cycles 0 and 1.
//    -> dinLocal=A at cycle 1, B at cycle 2, then 0; PVLocal matches routeComp of each dst.
//  3 Saturated network: dinW/E/S/N/Bypass all nonzero for 10 cycles with 1 flit queued.
//    -> dinLocal=0 throughout, inj_stall=10; then dinS=0 -> flit injected that cycle.
//  4 Full inject FIFO: push 4 flits with network saturated.
//    -> core_ready=0; 5th offer is not accepted; after 1 pop, core_ready=1 the next cycle.
//  5 Ejection overflow: ej_ready=0, 5 consecutive nonzero doutLocal.
//    -> first 4 stored in order, 5th dropped, ej_overflow=1.
//    -> then ej_ready=1 drains the 4 in order; full+pop+new flit in the same cycle is accepted without drop.
//  6 Zero core flit: core_valid=1, core_flit=0.
//    -> no push, occupancy unchanged, dinLocal stays 0.

Source files
------------

// File: rtl/local_ni_pkg.sv
// Shared flit format, productive-vector bit order and the route computation
// used to build PVLocal for flits entering the router's local port.
package local_ni_pkg;

    localparam int WIDTH_PORT = 16;
    localparam int WIDTH_PV   = 4;
    localparam int COORD_W    = 3;
    localparam int POS_X_DST  = 0;
    localparam int POS_Y_DST  = 3;

    // PV bit order, identical to what the router's allocator consumes
    localparam int PV_N = 0;
    localparam int PV_E = 1;
    localparam int PV_S = 2;
    localparam int PV_W = 3;

    function automatic logic [WIDTH_PV-1:0] route_comp(
        input logic                  valid,
        input logic [WIDTH_PORT-1:0] flit,
        input logic [COORD_W-1:0]    cur_x,
        input logic [COORD_W-1:0]    cur_y
    );
        logic [COORD_W-1:0]  dst_x;
        logic [COORD_W-1:0]  dst_y;
        logic [WIDTH_PV-1:0] pv;
        dst_x = flit[POS_X_DST +: COORD_W];
        dst_y = flit[POS_Y_DST +: COORD_W];
        pv    = '0;
        if (valid) begin
            pv[PV_N] = (dst_y < cur_y);
            pv[PV_E] = (dst_x > cur_x);
            pv[PV_S] = (dst_y > cur_y);
            pv[PV_W] = (dst_x < cur_x);
        end
        return pv;
    endfunction

endpackage

// File: rtl/local_ni_fifo.sv
// Small synchronous FIFO with a combinational head; head reads as zero when
// empty so downstream logic never sees stale storage after reset.
module ni_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // When full, a push is only taken alongside a pop: the write lands in the
    // slot being vacated, which is still read combinationally this cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/local_ni.sv
// Local network interface for a bufferless router: gates injection on a free
// router input channel and buffers unconditionally ejected flits for the core.
module local_ni
    import local_ni_pkg::*;
#(
    parameter int                 INJ_DEPTH = 4,
    parameter int                 EJ_DEPTH  = 4,
    parameter int                 CNT_W     = 16,
    parameter logic [COORD_W-1:0] POS_X     = '0,
    parameter logic [COORD_W-1:0] POS_Y     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH_PORT-1:0] core_flit,
    input  logic                  core_valid,
    output logic                  core_ready,
    input  logic [WIDTH_PORT-1:0] dinW,
    input  logic [WIDTH_PORT-1:0] dinE,
    input  logic [WIDTH_PORT-1:0] dinS,
    input  logic [WIDTH_PORT-1:0] dinN,
    input  logic [WIDTH_PORT-1:0] dinBypass,
    output logic [WIDTH_PORT-1:0] dinLocal,
    output logic [WIDTH_PV-1:0]   PVLocal,
    input  logic [WIDTH_PORT-1:0] doutLocal,
    output logic [WIDTH_PORT-1:0] ej_flit,
    output logic                  ej_valid,
    input  logic                  ej_ready,
    output logic                  ej_overflow,
    output logic [CNT_W-1:0]      inj_stall
);
    logic                  inj_full, inj_empty, ej_full, ej_empty;
    logic [WIDTH_PORT-1:0] inj_head;
    logic                  free, push_inj, pop_inj;
    logic                  push_ej, pop_ej, drop_ej, ej_in;
    logic [CNT_W-1:0]      inj_stall_q, inj_stall_d;
    logic                  ej_overflow_q, ej_overflow_d;

    assign core_ready = ~inj_full & ~reset;
    assign push_inj   = core_valid & core_ready & (|core_flit);

    // A same-cycle ejection is deliberately not treated as freeing a channel.
    assign free    = ~(|dinW) | ~(|dinE) | ~(|dinS) | ~(|dinN) | ~(|dinBypass);
    assign pop_inj = ~inj_empty & free;

    ni_fifo #(.WIDTH(WIDTH_PORT), .DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push_inj),
        .pop_i   (pop_inj),
        .data_i  (core_flit),
        .head_o  (inj_head),
        .full_o  (inj_full),
        .empty_o (inj_empty)
    );

    always_comb begin
        dinLocal = '0;
        PVLocal  = '0;
        if (pop_inj) begin
            dinLocal = inj_head;
            PVLocal  = route_comp(~inj_empty, inj_head, POS_X, POS_Y);
        end
    end

    assign ej_in    = |doutLocal;
    assign ej_valid = ~ej_empty;
    assign pop_ej   = ej_valid & ej_ready;
    assign push_ej  = ej_in & (~ej_full | pop_ej);
    assign drop_ej  = ej_in & ej_full & ~pop_ej;

    ni_fifo #(.WIDTH(WIDTH_PORT), .DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push_ej),
        .pop_i   (pop_ej),
        .data_i  (doutLocal),
        .head_o  (ej_flit),
        .full_o  (ej_full),
        .empty_o (ej_empty)
    );

    always_comb begin
        inj_stall_d   = inj_stall_q;
        ej_overflow_d = ej_overflow_q | drop_ej;
        if (~inj_empty & ~free & ~(&inj_stall_q)) begin
            inj_stall_d = inj_stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_stall_q   <= '0;
            ej_overflow_q <= 1'b0;
        end else begin
            inj_stall_q   <= inj_stall_d;
            ej_overflow_q <= ej_overflow_d;
        end
    end

    assign inj_stall   = inj_stall_q;
    assign ej_overflow = ej_overflow_q;

endmodule

// File: tb/tb_local_ni.sv
// Scenario bench for local_ni: directed tasks plus a randomized run, all
// checked against a queue-based model of the injection/ejection rules.
module tb_local_ni;
    localparam int W     = 16;
    localparam int PVW   = 4;
    localparam int INJ_D = 4;
    localparam int EJ_D  = 4;
    localparam int CW    = 4;
    localparam int CX    = 3;
    localparam int CY    = 4;
    localparam int STALL_MAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   core_flit;
    logic           core_valid;
    logic           core_ready;
    logic [W-1:0]   dinW, dinE, dinS, dinN, dinBypass;
    logic [W-1:0]   dinLocal;
    logic [PVW-1:0] PVLocal;
    logic [W-1:0]   doutLocal;
    logic [W-1:0]   ej_flit;
    logic           ej_valid;
    logic           ej_ready;
    logic           ej_overflow;
    logic [CW-1:0]  inj_stall;

    local_ni #(
        .INJ_DEPTH (INJ_D),
        .EJ_DEPTH  (EJ_D),
        .CNT_W     (CW),
        .POS_X     (3'(CX)),
        .POS_Y     (3'(CY))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_flit  (core_flit),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .dinW       (dinW),
        .dinE       (dinE),
        .dinS       (dinS),
        .dinN       (dinN),
        .dinBypass  (dinBypass),
        .dinLocal   (dinLocal),
        .PVLocal    (PVLocal),
        .doutLocal  (doutLocal),
        .ej_flit    (ej_flit),
        .ej_valid   (ej_valid),
        .ej_ready   (ej_ready),
        .ej_overflow(ej_overflow),
        .inj_stall  (inj_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [W-1:0]   m_inj[$];
    logic [W-1:0]   m_ej[$];
    int             m_stall;
    bit             m_ovf;
    logic [W-1:0]   exp_din, exp_ejf;
    logic [PVW-1:0] exp_pv;
    logic           exp_ready, exp_ejv;

    function automatic logic [PVW-1:0] ref_pv(input logic [W-1:0] f);
        int dx, dy;
        logic [PVW-1:0] pv;
        dx = int'(f[2:0]);
        dy = int'(f[5:3]);
        pv = '0;
        pv[0] = (dy < CY);
        pv[1] = (dx > CX);
        pv[2] = (dy > CY);
        pv[3] = (dx < CX);
        return pv;
    endfunction

    function automatic logic [W-1:0] rand_flit();
        return W'($urandom_range(1, 65535));
    endfunction

    function automatic bit net_free();
        return (dinW == 0) || (dinE == 0) || (dinS == 0) || (dinN == 0) || (dinBypass == 0);
    endfunction

    function automatic void model_eval();
        exp_ready = (m_inj.size() < INJ_D);
        exp_din   = (m_inj.size() > 0 && net_free()) ? m_inj[0] : '0;
        exp_pv    = (exp_din != 0) ? ref_pv(exp_din) : '0;
        exp_ejv   = (m_ej.size() > 0);
        exp_ejf   = exp_ejv ? m_ej[0] : '0;
    endfunction

    task automatic set_din(input bit saturated);
        dinW      = saturated ? rand_flit() : '0;
        dinE      = saturated ? rand_flit() : '0;
        dinS      = saturated ? rand_flit() : '0;
        dinN      = saturated ? rand_flit() : '0;
        dinBypass = saturated ? rand_flit() : '0;
    endtask

    // Advance one clock, applying the same-cycle decisions to the model.
    task automatic step();
        bit pop_i, push_i, stall_inc, pop_e, push_e, drop;
        logic [W-1:0] cf, dl;
        pop_i     = (m_inj.size() > 0) && net_free();
        push_i    = core_valid && (m_inj.size() < INJ_D) && (core_flit != 0);
        stall_inc = (m_inj.size() > 0) && !net_free();
        pop_e     = (m_ej.size() > 0) && ej_ready;
        push_e    = (doutLocal != 0) && ((m_ej.size() < EJ_D) || pop_e);
        drop      = (doutLocal != 0) && !push_e;
        cf = core_flit;
        dl = doutLocal;
        @(posedge clk);
        if (pop_i)  void'(m_inj.pop_front());
        if (push_i) m_inj.push_back(cf);
        if (stall_inc && m_stall < STALL_MAX) m_stall++;
        if (pop_e)  void'(m_ej.pop_front());
        if (push_e) m_ej.push_back(dl);
        if (drop)   m_ovf = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        core_flit  = '0;
        core_valid = 1'b0;
        doutLocal  = '0;
        ej_ready   = 1'b0;
        set_din(1'b0);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_inj.delete();
        m_ej.delete();
        m_stall = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (inj_stall !== '0) begin n_bad++; $display("FAIL powerup_stall got %h want 0", inj_stall); end
        n_cmp++; if (ej_valid !== 1'b0) begin n_bad++; $display("FAIL powerup_ej_valid got %b want 0", ej_valid); end
        do_reset();
        // Queue 3 flits under a saturated network and fill the ejection side past full.
        for (int i = 0; i < 5; i++) begin
            set_din(1'b1);
            core_valid = (i < 3);
            core_flit  = rand_flit();
            doutLocal  = rand_flit();
            ej_ready   = 1'b0;
            #1;
            step();
        end
        core_valid = 1'b0;
        doutLocal  = '0;
        dinW       = '0;
        #1;
        model_eval();
        n_cmp++; if (dinLocal !== exp_din) begin n_bad++; $display("FAIL prereset_din got %h want %h", dinLocal, exp_din); end
        reset = 1'b1;
        #1;
        n_cmp++; if (dinLocal !== '0) begin n_bad++; $display("FAIL reset_din got %h want 0", dinLocal); end
        n_cmp++; if (PVLocal !== '0) begin n_bad++; $display("FAIL reset_pv got %h want 0", PVLocal); end
        n_cmp++; if (ej_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ej_valid got %b want 0", ej_valid); end
        n_cmp++; if (ej_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ej_overflow); end
        n_cmp++; if (inj_stall !== '0) begin n_bad++; $display("FAIL reset_stall got %h want 0", inj_stall); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_inj.delete();
        m_ej.delete();
        m_stall = 0;
        m_ovf   = 1'b0;
        #1;
        n_cmp++; if (core_ready !== 1'b1) begin n_bad++; $display("FAIL postreset_ready got %b want 1", core_ready); end
        n_cmp++; if (dinLocal !== '0) begin n_bad++; $display("FAIL postreset_din got %h want 0", dinLocal); end
        n_cmp++; if (ej_flit !== '0) begin n_bad++; $display("FAIL postreset_ej_flit got %h want 0", ej_flit); end
        $display("test_reset done");
    endtask

    task automatic test_idle_inject();
        logic [W-1:0] a, b;
        logic [W-1:0] want_din[4];
        do_reset();
        a = rand_flit();
        b = rand_flit();
        want_din[0] = '0; want_din[1] = a; want_din[2] = b; want_din[3] = '0;
        for (int c = 0; c < 4; c++) begin
            core_valid = (c < 2);
            core_flit  = (c == 0) ? a : ((c == 1) ? b : '0);
            #1;
            n_cmp++; if (dinLocal !== want_din[c]) begin n_bad++; $display("FAIL idle_din c%0d got %h want %h", c, dinLocal, want_din[c]); end
            n_cmp++; if (PVLocal !== ((want_din[c] != 0) ? ref_pv(want_din[c]) : 4'h0))
                begin n_bad++; $display("FAIL idle_pv c%0d got %h want %h", c, PVLocal, ref_pv(want_din[c])); end
            $display("idle cycle %0d dinLocal=%h PVLocal=%h", c, dinLocal, PVLocal);
            step();
        end
    endtask

    task automatic test_saturated();
        logic [W-1:0] f;
        do_reset();
        f = rand_flit();
        set_din(1'b1);
        core_valid = 1'b1;
        core_flit  = f;
        #1;
        step();
        core_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            set_din(1'b1);
            #1;
            n_cmp++; if (dinLocal !== '0) begin n_bad++; $display("FAIL sat_din c%0d got %h want 0", c, dinLocal); end
            step();
        end
        dinS = '0;
        #1;
        n_cmp++; if (inj_stall !== CW'(10)) begin n_bad++; $display("FAIL sat_stall got %0d want 10", inj_stall); end
        n_cmp++; if (dinLocal !== f) begin n_bad++; $display("FAIL sat_release got %h want %h", dinLocal, f); end
        n_cmp++; if (PVLocal !== ref_pv(f)) begin n_bad++; $display("FAIL sat_pv got %h want %h", PVLocal, ref_pv(f)); end
        $display("saturated: flit %h injected after %0d stall cycles", dinLocal, inj_stall);
        step();
        #1;
        n_cmp++; if (dinLocal !== '0) begin n_bad++; $display("FAIL sat_after got %h want 0", dinLocal); end
        // Keep one flit blocked long enough to hit the counter ceiling.
        set_din(1'b1);
        core_valid = 1'b1;
        core_flit  = rand_flit();
        step();
        core_valid = 1'b0;
        for (int c = 0; c < 25; c++) step();
        #1;
        n_cmp++; if (inj_stall !== CW'(STALL_MAX)) begin n_bad++; $display("FAIL stall_saturate got %0d want %0d", inj_stall, STALL_MAX); end
    endtask

    task automatic test_full_inject();
        logic [W-1:0] x;
        do_reset();
        set_din(1'b1);
        for (int i = 0; i < 4; i++) begin
            core_valid = 1'b1;
            core_flit  = rand_flit();
            #1;
            n_cmp++; if (core_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_fill i%0d got %b want 1", i, core_ready); end
            $display("full: push %h", core_flit);
            step();
        end
        x = rand_flit();
        core_flit = x;
        #1;
        n_cmp++; if (core_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", core_ready); end
        step();
        core_valid = 1'b0;
        dinN = '0;
        #1;
        model_eval();
        n_cmp++; if (core_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_popcycle got %b want 0", core_ready); end
        n_cmp++; if (dinLocal !== exp_din) begin n_bad++; $display("FAIL full_pop got %h want %h", dinLocal, exp_din); end
        step();
        set_din(1'b1);
        #1;
        n_cmp++; if (core_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_after got %b want 1", core_ready); end
        step();
        set_din(1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            model_eval();
            n_cmp++; if (dinLocal !== exp_din) begin n_bad++; $display("FAIL full_drain c%0d got %h want %h", c, dinLocal, exp_din); end
            n_cmp++; if (x != 0 && dinLocal === x) begin n_bad++; $display("FAIL full_refused_seen got %h want not %h", dinLocal, x); end
            step();
        end
    endtask

    task automatic test_ej_overflow();
        logic [W-1:0] f[5];
        logic [W-1:0] nf;
        logic [W-1:0] lst[4];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            f[i] = rand_flit();
            doutLocal = f[i];
            #1;
            n_cmp++; if (ej_overflow !== 1'b0) begin n_bad++; $display("FAIL ej_ovf_early i%0d got %b want 0", i, ej_overflow); end
            step();
        end
        nf = rand_flit();
        doutLocal = nf;
        ej_ready  = 1'b1;
        #1;
        n_cmp++; if (ej_overflow !== 1'b1) begin n_bad++; $display("FAIL ej_ovf got %b want 1", ej_overflow); end
        n_cmp++; if (ej_flit !== f[0]) begin n_bad++; $display("FAIL ej_head got %h want %h", ej_flit, f[0]); end
        step();
        doutLocal = '0;
        lst[0] = f[1]; lst[1] = f[2]; lst[2] = f[3]; lst[3] = nf;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (ej_flit !== lst[i]) begin n_bad++; $display("FAIL ej_drain i%0d got %h want %h", i, ej_flit, lst[i]); end
            n_cmp++; if (ej_valid !== 1'b1) begin n_bad++; $display("FAIL ej_valid_drain i%0d got %b want 1", i, ej_valid); end
            $display("eject: %h", ej_flit);
            step();
        end
        #1;
        n_cmp++; if (ej_valid !== 1'b0) begin n_bad++; $display("FAIL ej_empty got %b want 0", ej_valid); end
        n_cmp++; if (ej_overflow !== 1'b1) begin n_bad++; $display("FAIL ej_ovf_sticky got %b want 1", ej_overflow); end
    endtask

    task automatic test_zero_flit();
        do_reset();
        set_din(1'b1);
        core_valid = 1'b1;
        core_flit  = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (core_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready c%0d got %b want 1", c, core_ready); end
            step();
        end
        set_din(1'b0);
        #1;
        n_cmp++; if (dinLocal !== '0) begin n_bad++; $display("FAIL zero_din got %h want 0", dinLocal); end
        n_cmp++; if (inj_stall !== '0) begin n_bad++; $display("FAIL zero_stall got %0d want 0", inj_stall); end
        core_valid = 1'b0;
        step();
        $display("zero flit: no push observed");
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            dinW      = ($urandom_range(0, 3) == 0) ? '0 : rand_flit();
            dinE      = ($urandom_range(0, 3) == 0) ? '0 : rand_flit();
            dinS      = ($urandom_range(0, 3) == 0) ? '0 : rand_flit();
            dinN      = ($urandom_range(0, 3) == 0) ? '0 : rand_flit();
            dinBypass = ($urandom_range(0, 3) == 0) ? '0 : rand_flit();
            if (c >= 150 && c < 200) set_din(1'b1);
            core_valid = ($urandom_range(0, 9) < 6);
            core_flit  = ($urandom_range(0, 9) == 0) ? '0 : rand_flit();
            doutLocal  = ($urandom_range(0, 9) < 4) ? rand_flit() : '0;
            ej_ready   = ($urandom_range(0, 9) < 5);
            #1;
            model_eval();
            n_cmp++; if (dinLocal !== exp_din) begin n_bad++; $display("FAIL rnd_din c%0d got %h want %h", c, dinLocal, exp_din); end
            n_cmp++; if (PVLocal !== exp_pv) begin n_bad++; $display("FAIL rnd_pv c%0d got %h want %h", c, PVLocal, exp_pv); end
            n_cmp++; if (core_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready c%0d got %b want %b", c, core_ready, exp_ready); end
            n_cmp++; if (ej_valid !== exp_ejv) begin n_bad++; $display("FAIL rnd_ejv c%0d got %b want %b", c, ej_valid, exp_ejv); end
            n_cmp++; if (ej_flit !== exp_ejf) begin n_bad++; $display("FAIL rnd_ejf c%0d got %h want %h", c, ej_flit, exp_ejf); end
            n_cmp++; if (inj_stall !== CW'(m_stall)) begin n_bad++; $display("FAIL rnd_stall c%0d got %0d want %0d", c, inj_stall, m_stall); end
            n_cmp++; if (ej_overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf c%0d got %b want %b", c, ej_overflow, m_ovf); end
            step();
        end
        $display("random: 400 cycles done");
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        m_stall = 0;
        m_ovf   = 1'b0;
        test_reset();
        test_idle_inject();
        test_saturated();
        test_full_inject();
        test_ej_overflow();
        test_zero_flit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
